// File: rtl/serial_half_sub.sv
// ============================================================================
// Module  : serial_half_sub
// Brief   : Bit-serial A-B subtractor, LSB-first, with final unsigned borrow.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module serial_half_sub #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             bit_valid,
  input  logic             a_bit,
  input  logic             b_bit,
  output logic             busy,
  output logic             diff_bit,
  output logic             diff_valid,
  output logic [WIDTH-1:0] diff_word,
  output logic             borrow_out,
  output logic             done
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] C_LAST_IDX = CNT_W'(WIDTH - 1);

  state_t           state_q, state_d;
  logic             borrow_q;
  logic [CNT_W-1:0] count_q;
  logic [WIDTH-1:0] diff_word_q;
  logic             diff_bit_q;
  logic             diff_valid_q;
  logic             done_q;
  logic             borrow_out_q;

  logic w_accept;
  logic w_last;
  logic w_clear;
  logic w_diff;
  logic w_borrow_next;

  // Full-subtractor cell: the borrow in plays the role of a carried state.
  assign w_diff        = a_bit ^ b_bit ^ borrow_q;
  assign w_borrow_next = (~a_bit & b_bit) | (~(a_bit ^ b_bit) & borrow_q);

  always_comb begin
    state_d  = state_q;
    w_accept = 1'b0;
    w_last   = 1'b0;
    w_clear  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_RUN;
          w_clear = 1'b1;
        end
      end
      S_RUN: begin
        if (bit_valid) begin
          w_accept = 1'b1;
          if (count_q == C_LAST_IDX) begin
            w_last  = 1'b1;
            state_d = S_DONE;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      borrow_q     <= 1'b0;
      count_q      <= '0;
      diff_word_q  <= '0;
      diff_bit_q   <= 1'b0;
      diff_valid_q <= 1'b0;
      done_q       <= 1'b0;
      borrow_out_q <= 1'b0;
    end else begin
      diff_valid_q <= w_accept;
      done_q       <= w_last;
      if (w_clear) begin
        borrow_q    <= 1'b0;
        count_q     <= '0;
        diff_word_q <= '0;
      end else if (w_accept) begin
        diff_bit_q  <= w_diff;
        diff_word_q <= {w_diff, diff_word_q[WIDTH-1:1]};
        borrow_q    <= w_borrow_next;
        // Wrap explicitly so non-power-of-two widths restart cleanly.
        count_q     <= w_last ? '0 : count_q + 1'b1;
        if (w_last) begin
          borrow_out_q <= w_borrow_next;
        end
      end
    end
  end

  assign busy       = (state_q == S_RUN);
  assign diff_bit   = diff_bit_q;
  assign diff_valid = diff_valid_q;
  assign diff_word  = diff_word_q;
  assign borrow_out = borrow_out_q;
  assign done       = done_q;

endmodule

`default_nettype wire

// File: tb/tb_serial_half_sub.sv
// ============================================================================
// Module  : tb_serial_half_sub
// Brief   : Self-checking bench for serial_half_sub (table + random words).
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_serial_half_sub;

  localparam int WIDTH = 8;

  logic             clk;
  logic             rst;
  logic             start;
  logic             bit_valid;
  logic             a_bit;
  logic             b_bit;
  logic             busy;
  logic             diff_bit;
  logic             diff_valid;
  logic [WIDTH-1:0] diff_word;
  logic             borrow_out;
  logic             done;

  int n_vec;
  int n_err;

  typedef struct {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    int               gap;
    bit               pulse_start;
    logic [WIDTH-1:0] exp_word;
    logic             exp_borrow;
  } vec_t;

  vec_t tbl[6];

  serial_half_sub #(.WIDTH(WIDTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .bit_valid  (bit_valid),
    .a_bit      (a_bit),
    .b_bit      (b_bit),
    .busy       (busy),
    .diff_bit   (diff_bit),
    .diff_valid (diff_valid),
    .diff_word  (diff_word),
    .borrow_out (borrow_out),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: whole-word modulo arithmetic and unsigned compare.
  function automatic logic [WIDTH-1:0] ref_diff(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    return a - b;
  endfunction

  function automatic logic ref_borrow(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    return (a < b);
  endfunction

  // Entered and left in IDLE, one #1 past a rising edge.
  task automatic run_word(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input int gap,
                          input bit pulse_start, input logic [WIDTH-1:0] exp_w, input logic exp_b);
    int pulses;
    pulses    = 0;
    start     = 1'b1;
    bit_valid = 1'b0;
    step();
    start = 1'b0;
    chk("busy_after_start", busy, 1'b1);
    for (int i = 0; i < WIDTH; i++) begin
      int ng;
      ng = (gap > 0) ? int'($urandom_range(0, gap)) : 0;
      for (int g = 0; g < ng; g++) begin
        bit_valid = 1'b0;
        a_bit     = 1'($urandom);
        b_bit     = 1'($urandom);
        step();
        chk("stall_no_valid", diff_valid, 1'b0);
        chk("stall_busy", busy, 1'b1);
      end
      bit_valid = 1'b1;
      a_bit     = a[i];
      b_bit     = b[i];
      start     = (pulse_start && i == 3);
      step();
      start = 1'b0;
      if (diff_valid) pulses++;
      chk("diff_bit", diff_bit, exp_w[i]);
      chk("done_timing", done, (i == WIDTH - 1));
      chk("busy_run", busy, (i != WIDTH - 1));
    end
    bit_valid = 1'b0;
    start     = pulse_start;
    step();
    start = 1'b0;
    chk("valid_pulses", pulses, WIDTH);
    chk("done_one_cycle", done, 1'b0);
    chk("idle_busy", busy, 1'b0);
    chk("diff_word", diff_word, exp_w);
    chk("borrow_out", borrow_out, exp_b);
    if (pulse_start) begin
      step();
      chk("no_restart", busy, 1'b0);
    end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    tbl[0] = '{a: 8'h05, b: 8'h03, gap: 0, pulse_start: 1'b0, exp_word: 8'h02, exp_borrow: 1'b0};
    tbl[1] = '{a: 8'h03, b: 8'h05, gap: 0, pulse_start: 1'b0, exp_word: 8'hFE, exp_borrow: 1'b1};
    tbl[2] = '{a: 8'hFF, b: 8'hFF, gap: 0, pulse_start: 1'b0, exp_word: 8'h00, exp_borrow: 1'b0};
    tbl[3] = '{a: 8'h80, b: 8'h01, gap: 2, pulse_start: 1'b0, exp_word: 8'h7F, exp_borrow: 1'b0};
    tbl[4] = '{a: 8'hA5, b: 8'h3C, gap: 1, pulse_start: 1'b1, exp_word: 8'h69, exp_borrow: 1'b0};
    tbl[5] = '{a: 8'h00, b: 8'h01, gap: 0, pulse_start: 1'b0, exp_word: 8'hFF, exp_borrow: 1'b1};

    rst       = 1'b1;
    start     = 1'b1;
    bit_valid = 1'b0;
    a_bit     = 1'b0;
    b_bit     = 1'b0;
    step();
    step();
    chk("rst_busy", busy, 1'b0);
    chk("rst_diff_valid", diff_valid, 1'b0);
    chk("rst_diff_word", diff_word, '0);
    chk("rst_borrow_out", borrow_out, 1'b0);
    chk("rst_done", done, 1'b0);
    rst   = 1'b0;
    start = 1'b0;
    step();

    for (int k = 0; k < 6; k++) begin
      run_word(tbl[k].a, tbl[k].b, tbl[k].gap, tbl[k].pulse_start, tbl[k].exp_word, tbl[k].exp_borrow);
    end

    // bit_valid in IDLE must not disturb held results (borrow_out is 1 here).
    for (int k = 0; k < 5; k++) begin
      bit_valid = 1'b1;
      a_bit     = 1'($urandom);
      b_bit     = 1'($urandom);
      step();
      chk("idle_no_valid", diff_valid, 1'b0);
      chk("idle_word_held", diff_word, 8'hFF);
      chk("idle_borrow_held", borrow_out, 1'b1);
      chk("idle_not_busy", busy, 1'b0);
    end
    bit_valid = 1'b0;

    // Abort after four accepted pairs.
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bit_valid = 1'b1;
      a_bit     = 1'($urandom);
      b_bit     = 1'($urandom);
      step();
    end
    rst = 1'b1;
    step();
    rst       = 1'b0;
    bit_valid = 1'b0;
    chk("abort_busy", busy, 1'b0);
    chk("abort_diff_bit", diff_bit, 1'b0);
    chk("abort_diff_valid", diff_valid, 1'b0);
    chk("abort_diff_word", diff_word, '0);
    chk("abort_borrow_out", borrow_out, 1'b0);
    chk("abort_done", done, 1'b0);
    for (int i = 0; i < 3; i++) begin
      bit_valid = 1'b1;
      step();
      chk("abort_no_done", done, 1'b0);
      chk("abort_stays_idle", busy, 1'b0);
    end
    bit_valid = 1'b0;
    run_word(8'h10, 8'h01, 0, 1'b0, 8'h0F, 1'b0);

    for (int r = 0; r < 20; r++) begin
      logic [WIDTH-1:0] ra;
      logic [WIDTH-1:0] rb;
      ra = WIDTH'($urandom);
      rb = WIDTH'($urandom);
      run_word(ra, rb, int'($urandom_range(0, 3)), 1'($urandom), ref_diff(ra, rb), ref_borrow(ra, rb));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
